// File: rtl/icache_mem_arbiter_pkg.sv
// Shared types and helpers for the instruction-cache refill arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE=0, ISSUE=1, RESP=2)
//   line_align  : clears the line-offset bits of a byte address
package icache_mem_arbiter_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr,
                                                   input int off_bits);
    logic [ADDR_W-1:0] mask;
    mask = '1;
    mask = mask << off_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/icache_mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at ptr+1 and wrapping around; the first set bit wins.
//   req   : request vector, N bits
//   ptr   : index of the last grant (lowest priority this round)
//   grant : index of the picked request (0 when none)
//   any   : at least one request bit set
module icache_mem_arbiter_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  int idx;

  // Walk the search order backwards so the earliest candidate is the last
  // assignment and therefore the one that sticks.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = N; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx[W-1:0]]) begin
        grant = idx[W-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_mem_arbiter.sv
// Shares one wide line-refill memory port between NUM_REQ icache refill masters.
// Round-robin grant, one outstanding line fetch at a time.
//
// Handshake (both sides): valid is a level held by the master until it sees a
// one-cycle ready pulse; the data accompanying ready is valid in that same cycle.
//
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   req_valid     per-requester refill request (level)
//   req_addr      request addresses, slice r = [32*r +: 32]
//   req_ready     one-cycle pulse to the granted requester, one-hot or zero
//   req_rdata     registered line data, broadcast to all requesters
//   dn_valid      downstream request, held until dn_ready
//   dn_ready      downstream completion pulse
//   dn_addr       line-aligned downstream address
//   dn_rdata      downstream line data
//   grant_id      index of the current/last grant
//   busy          FSM not in IDLE
//   state_dbg     current FSM state
module icache_mem_arbiter
  import icache_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int LINE_BYTES = 16,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OFF_BITS  = $clog2(LINE_BYTES)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [32*NUM_REQ-1:0]     req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [8*LINE_BYTES-1:0]   req_rdata,
  output logic                      dn_valid,
  input  logic                      dn_ready,
  output logic [31:0]               dn_addr,
  input  logic [8*LINE_BYTES-1:0]   dn_rdata,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output arb_state_t                state_dbg
);

  arb_state_t         state;
  logic [GW-1:0]      rr_ptr;
  logic               aborted;
  logic [GW-1:0]      pick;
  logic               pick_any;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               abort_now;

  icache_mem_arbiter_rr_pick #(
    .N (NUM_REQ),
    .W (GW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick),
    .any   (pick_any)
  );

  always_comb begin
    grant_onehot           = '0;
    grant_onehot[grant_id] = 1'b1;
  end

  // Abort is sticky across ISSUE and also covers the cycle in which dn_ready
  // arrives together with the granted requester dropping valid.
  assign abort_now = aborted | ~req_valid[grant_id];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      req_ready <= '0;
      req_rdata <= '0;
      dn_valid  <= 1'b0;
      dn_addr   <= '0;
      grant_id  <= '0;
      rr_ptr    <= GW'(NUM_REQ - 1);
      aborted   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= '0;
          if (pick_any) begin
            grant_id <= pick;
            rr_ptr   <= pick;
            dn_addr  <= line_align(req_addr[32*pick +: 32], OFF_BITS);
            dn_valid <= 1'b1;
            aborted  <= 1'b0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dn_ready) begin
            dn_valid <= 1'b0;
            aborted  <= 1'b0;
            if (!abort_now) begin
              req_rdata <= dn_rdata;
              req_ready <= grant_onehot;
              state     <= ST_RESP;
            end else begin
              // Line is dropped; requester has already gone away.
              state <= ST_IDLE;
            end
          end else begin
            aborted <= abort_now;
          end
        end
        ST_RESP: begin
          req_ready <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= '0;
          dn_valid  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Directed bench for icache_mem_arbiter with NUM_REQ=2, LINE_BYTES=16.
module tb_icache_mem_arbiter;
  import icache_mem_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int LB = 16;
  localparam int DW = 8 * LB;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [32*NR-1:0] req_addr  = '0;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    req_rdata;
  logic             dn_valid;
  logic             dn_ready = 1'b0;
  logic [31:0]      dn_addr;
  logic [DW-1:0]    dn_rdata = '0;
  logic [0:0]       grant_id;
  logic             busy;
  arb_state_t       state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  icache_mem_arbiter #(.NUM_REQ(NR), .LINE_BYTES(LB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .req_rdata (req_rdata),
    .dn_valid  (dn_valid),
    .dn_ready  (dn_ready),
    .dn_addr   (dn_addr),
    .dn_rdata  (dn_rdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // driver tasks: inputs change 1 time unit after the rising edge, outputs are
  // sampled there too, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  logic [DW-1:0] d_last;
  logic [0:0]    exp_g[4];
  logic [31:0]   exp_a[4];

  initial begin
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_a = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0100, 32'h0000_0200};

    #1;
    do_reset();
    // reset state
    check("rst_dn_valid", DW'(dn_valid), DW'(1'b0));
    check("rst_req_ready", DW'(req_ready), DW'(2'b00));
    check("rst_busy", DW'(busy), DW'(1'b0));
    check("rst_dn_addr", DW'(dn_addr), DW'(32'h0));
    check("rst_rdata", req_rdata, '0);
    check("rst_state", DW'(state_dbg), DW'(ST_IDLE));

    // 1: single request, response two cycles after dn_valid
    req_addr[31:0] = 32'h0000_1234;
    req_valid      = 2'b01;
    tick();
    check("t1_dn_valid", DW'(dn_valid), DW'(1'b1));
    check("t1_dn_addr", DW'(dn_addr), DW'(32'h0000_1230));
    check("t1_grant", DW'(grant_id), DW'(1'b0));
    check("t1_busy", DW'(busy), DW'(1'b1));
    req_addr[31:0] = 32'h0000_5678;  // must not disturb dn_addr now
    tick();
    check("t1_addr_hold", DW'(dn_addr), DW'(32'h0000_1230));
    check("t1_ready_early", DW'(req_ready), DW'(2'b00));
    dn_ready = 1'b1;
    dn_rdata = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    tick();
    dn_ready = 1'b0;
    req_valid = 2'b00;
    check("t1_ready", DW'(req_ready), DW'(2'b01));
    check("t1_rdata", req_rdata, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    check("t1_dn_drop", DW'(dn_valid), DW'(1'b0));
    check("t1_state_resp", DW'(state_dbg), DW'(ST_RESP));
    tick();
    check("t1_ready_off", DW'(req_ready), DW'(2'b00));
    check("t1_idle", DW'(busy), DW'(1'b0));

    // 2: both valid after reset, grants alternate 0,1,0,1
    do_reset();
    req_addr  = {32'h0000_0205, 32'h0000_0100};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t2_grant%0d", k), DW'(grant_id), DW'(exp_g[k]));
      check($sformatf("t2_addr%0d", k), DW'(dn_addr), DW'(exp_a[k]));
      dn_ready = 1'b1;
      dn_rdata = DW'(32'hA000_0000 + k);
      tick();
      dn_ready = 1'b0;
      check($sformatf("t2_ready%0d", k), DW'(req_ready), (k % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
      check($sformatf("t2_rdata%0d", k), req_rdata, DW'(32'hA000_0000 + k));
      tick();
      check($sformatf("t2_rdy_off%0d", k), DW'(req_ready), DW'(2'b00));
    end
    d_last = DW'(32'hA000_0003);

    // 3: abort, requester 0 drops during ISSUE; requester 1 follows
    tick();
    check("t3_grant0", DW'(grant_id), DW'(1'b0));
    req_valid = 2'b10;
    tick();
    check("t3_dn_held", DW'(dn_valid), DW'(1'b1));
    dn_ready = 1'b1;
    dn_rdata = 128'hdead_beef;
    tick();
    dn_ready = 1'b0;
    check("t3_no_pulse", DW'(req_ready), DW'(2'b00));
    check("t3_rdata_kept", req_rdata, d_last);
    check("t3_back_idle", DW'(state_dbg), DW'(ST_IDLE));
    check("t3_dn_off", DW'(dn_valid), DW'(1'b0));
    tick();
    check("t3_grant1", DW'(grant_id), DW'(1'b1));
    check("t3_addr1", DW'(dn_addr), DW'(32'h0000_0200));
    dn_ready = 1'b1;
    dn_rdata = 128'h1111;
    tick();
    dn_ready  = 1'b0;
    req_valid = 2'b00;
    check("t3_ready1", DW'(req_ready), DW'(2'b10));
    tick();

    // dn_ready in IDLE is ignored
    dn_ready = 1'b1;
    dn_rdata = 128'h2222;
    tick();
    dn_ready = 1'b0;
    check("idle_dn_busy", DW'(busy), DW'(1'b0));
    check("idle_dn_ready", DW'(req_ready), DW'(2'b00));
    check("idle_dn_rdata", req_rdata, 128'h1111);

    // 4: back-to-back with dn_ready always high -> one grant per 3 cycles
    req_valid = 2'b01;
    dn_ready  = 1'b1;
    dn_rdata  = 128'h3333;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t4_dn_valid%0d", k), DW'(dn_valid), (k % 3 == 0) ? DW'(1'b1) : DW'(1'b0));
      check($sformatf("t4_ready%0d", k), DW'(req_ready), (k % 3 == 1) ? DW'(2'b01) : DW'(2'b00));
    end
    dn_ready  = 1'b0;
    req_valid = 2'b00;
    tick();

    // 5: reset in the middle of ISSUE
    req_valid = 2'b01;
    tick();
    check("t5_busy_pre", DW'(busy), DW'(1'b1));
    req_valid = 2'b11;
    resetn    = 1'b0;
    tick();
    resetn = 1'b1;
    check("t5_dn_valid", DW'(dn_valid), DW'(1'b0));
    check("t5_busy", DW'(busy), DW'(1'b0));
    check("t5_rdata", req_rdata, '0);
    tick();
    check("t5_fresh_grant", DW'(grant_id), DW'(1'b0));
    check("t5_fresh_addr", DW'(dn_addr), DW'(32'h0000_0100));
    req_valid = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
